serial_alu16: RTL and testbench

Bit-serial 16-bit arithmetic/logic unit for the ALU area. It performs the same bitwise AND as the combinational 16-bit gate array, plus OR, XOR and ADD, using one 1-bit datapath slice stepped LSB-first over 16 clock cycles. A start/busy/done handshake connects it to a multicycle controller. It trades latency for area, and the combinational 16-bit units act as its golden model.

---
 rtl/serial_alu16.sv | 138 +++++++++++++
 tb/tb_serial_alu16.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu16.sv
// Bit-serial ALU: one 1-bit slice stepped LSB-first over WIDTH cycles.
// Supports AND/OR/XOR/ADD with a start/busy/done handshake.
module serial_alu16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [1:0] OpAnd = 2'b00;
    localparam logic [1:0] OpOr  = 2'b01;
    localparam logic [1:0] OpXor = 2'b10;
    localparam logic [1:0] OpAdd = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic             slice_bit;
    logic             slice_c;
    logic [WIDTH-1:0] sh_next;

    // One-bit datapath slice; carry stays 0 for logic ops.
    always_comb begin
        slice_bit = 1'b0;
        slice_c   = 1'b0;
        unique case (op_q)
            OpAnd: slice_bit = a_q[0] & b_q[0];
            OpOr:  slice_bit = a_q[0] | b_q[0];
            OpXor: slice_bit = a_q[0] ^ b_q[0];
            OpAdd: begin
                slice_bit = a_q[0] ^ b_q[0] ^ c_q;
                slice_c   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
            end
            default: ;
        endcase
    end

    assign sh_next = {slice_bit, sh_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    sh_d    = '0;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sh_d  = sh_next;
                c_d   = slice_c;
                cnt_d = cnt_q + 1'b1;
                // Visible outputs update only here, so partial results never leak.
                if (cnt_q == LastStep) begin
                    state_d  = StDone;
                    result_d = sh_next;
                    carry_d  = slice_c;
                    zero_d   = (sh_next == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= OpAnd;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_alu16.sv
// Directed and random checks of serial_alu16 against a combinational reference.
module tb_serial_alu16;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    serial_alu16 #(.WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        z;
    } vec_t;

    vec_t vecs[10];

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [1:0] o, input logic [15:0] x,
                                          input logic [15:0] y);
        case (o)
            2'b00:   model = {1'b0, x & y};
            2'b01:   model = {1'b0, x | y};
            2'b10:   model = {1'b0, x ^ y};
            default: model = {1'b0, x} + {1'b0, y};
        endcase
    endfunction

    // Issue one operation, count busy cycles, then check the done cycle and outputs.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] er, input logic ec,
                          input logic ez);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a     = ~x;
        b     = ~y;
        cyc   = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check16({nm, " busy_cycles"}, 16'(cyc), 16'd16);
        check1({nm, " done"}, done, 1'b1);
        check1({nm, " busy_at_done"}, busy, 1'b0);
        check16({nm, " result"}, result, er);
        check1({nm, " carry"}, carry, ec);
        check1({nm, " zero"}, zero, ez);
        @(negedge clk);
        check1({nm, " done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        logic [16:0] m;
        logic [15:0] ra, rb;
        logic [1:0]  ro;
        logic        ok;
        int          last_done, n_done;

        vecs[0] = '{2'b00, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
        vecs[1] = '{2'b11, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{2'b11, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
        vecs[3] = '{2'b10, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{2'b01, 16'h8001, 16'h0180, 16'h8181, 1'b0, 1'b0};
        vecs[5] = '{2'b11, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0};
        vecs[7] = '{2'b00, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[8] = '{2'b10, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0, 1'b0};
        vecs[9] = '{2'b11, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check1("reset busy", busy, 1'b0);
        check1("reset done", done, 1'b0);
        check16("reset result", result, 16'h0000);
        check1("reset carry", carry, 1'b0);
        check1("reset zero", zero, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].c, vecs[i].z);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ro = 2'($urandom_range(0, 3));
            m  = model(ro, ra, rb);
            run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, m[15:0], m[16],
                   m[15:0] == 16'h0);
        end

        // Start during RUN must be ignored; result must hold the previous value mid-run.
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (!busy || done) ok = 1'b0;
            start = (k >= 2 && k <= 9);
            op = 2'b00; a = 16'hFFFF; b = 16'hFFFF;
            if (k == 8) check16("ign result_held", result, m[15:0]);
            @(negedge clk);
        end
        start = 1'b0;
        check1("ign busy16", ok, 1'b1);
        check1("ign done", done, 1'b1);
        check16("ign result", result, 16'h3333);
        check1("ign carry", carry, 1'b0);
        @(negedge clk);
        check1("ign no_restart", busy, 1'b0);

        // Reset at RUN cycle 8 aborts with no done.
        start = 1'b1; op = 2'b11; a = 16'h1234; b = 16'h4321;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check1("rst pre busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check1("rst busy", busy, 1'b0);
        check1("rst done", done, 1'b0);
        check16("rst result", result, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) ok = 1'b0;
        end
        check1("rst no_done", ok, 1'b1);
        run_op("post_rst", 2'b11, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);

        // Start held high: a result every 17 cycles.
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 16'h0001; b = 16'h0001;
        @(negedge clk);
        ok = 1'b1; last_done = -1; n_done = 0;
        for (int i = 0; i <= 52; i++) begin
            if (busy && done) ok = 1'b0;
            if (done) begin
                n_done++;
                check16("b2b result", result, 16'h0002);
                if (last_done < 0) check16("b2b first", 16'(i), 16'd16);
                else check16("b2b period", 16'(i - last_done), 16'd17);
                last_done = i;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check1("b2b never_both", ok, 1'b1);
        check16("b2b count", 16'(n_done), 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
